uart_fifo_core: RTL

Parametrised successor to the single-buffer UART core: full-duplex UART with TX and RX FIFOs of configurable depth and runtime-selectable frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits). RX flags framing errors, parity errors and overrun. Sits behind the Wishbone register wrapper; the wrapper maps streams and status onto registers.

---
 rtl/uart_pkg.sv | 52 +++++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_fifo_core.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART core.
//   parity_t     : decoded parity mode
//   tx_state_t   : transmit frame FSM states
//   rx_state_t   : receive frame FSM states
//   DIV_MIN      : smallest usable bit period in clk cycles
//   dbits_mask   : data-bit code -> mask of active data bits
//   dbits_last   : data-bit code -> index of the last data bit
//   parity_decode: cfg_parity code -> parity_t (code 3 is treated as none)
package uart_pkg;

   localparam int unsigned DIV_MIN = 4;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   function automatic logic [7:0] dbits_mask(input logic [1:0] code);
      return 8'hFF >> (2'd3 - code);
   endfunction

   function automatic logic [2:0] dbits_last(input logic [1:0] code);
      return {1'b0, code} + 3'd4;
   endfunction

   function automatic parity_t parity_decode(input logic [1:0] code);
      case (code)
         2'd1:    return PAR_EVEN;
         2'd2:    return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO.
//   clk, resetn : clock, synchronous active-low reset (empties the FIFO)
//   push/wr_data: write request and data; accepted when not full, or when
//                 a pop frees an entry in the same cycle
//   pop         : remove head; ignored while empty
//   rd_data     : head entry, zero while empty
//   full/empty  : occupancy flags
//   level       : number of stored entries
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (resetn && do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs and runtime frame format.
//   clk, resetn          : clock, synchronous active-low reset
//   cfg_en               : enables TX launch and RX start detection
//   cfg_div              : bit period in clk cycles (values below 4 act as 4)
//   cfg_dbits/parity/stop2 : frame format, latched at frame start
//   tx_data/valid/ready  : TX FIFO push stream
//   rx_data/perr/ferr/valid/ready : RX FIFO head and pop
//   rx_overrun, ovr_clr  : sticky dropped-frame flag and its clear
//   tx_level, rx_level   : FIFO occupancies
//   tx_busy              : transmitter mid-frame
//   ser_tx, ser_rx       : serial lines (ser_rx asynchronous)
module uart_fifo_core
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cfg_en,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [1:0]       cfg_dbits,
   input  logic [1:0]       cfg_parity,
   input  logic             cfg_stop2,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_perr,
   output logic             rx_ferr,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             rx_overrun,
   input  logic             ovr_clr,
   output logic [LVL_W-1:0] tx_level,
   output logic [LVL_W-1:0] rx_level,
   output logic             tx_busy,
   output logic             ser_tx,
   input  logic             ser_rx
);

   logic [DIV_W-1:0] div_eff;
   logic [7:0]       cfg_mask;
   parity_t          cfg_par;

   assign div_eff  = (cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_div;
   assign cfg_mask = dbits_mask(cfg_dbits);
   assign cfg_par  = parity_decode(cfg_parity);

   // ---------------- TX FIFO ----------------
   logic [7:0] tx_head;
   logic       tx_full, tx_empty, tx_pop;

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
      .clk(clk), .resetn(resetn),
      .push(tx_valid), .wr_data(tx_data),
      .pop(tx_pop), .rd_data(tx_head),
      .full(tx_full), .empty(tx_empty), .level(tx_level)
   );

   assign tx_ready = !tx_full;

   // ---------------- TX FSM ----------------
   tx_state_t        tx_state, tx_state_n;
   logic [DIV_W-1:0] tx_cnt, tx_cnt_n, tx_div_m1, tx_div_m1_n;
   logic [2:0]       tx_bit, tx_bit_n, tx_last, tx_last_n;
   logic [7:0]       tx_shift, tx_shift_n;
   parity_t          tx_par, tx_par_n;
   logic             tx_stop2, tx_stop2_n, tx_stopn, tx_stopn_n;
   logic             tx_pbit, tx_pbit_n, tx_line_n, tx_tick, tx_launch;

   assign tx_busy = (tx_state != TX_IDLE);

   always_comb begin
      tx_state_n  = tx_state;
      tx_cnt_n    = tx_cnt;
      tx_div_m1_n = tx_div_m1;
      tx_bit_n    = tx_bit;
      tx_last_n   = tx_last;
      tx_shift_n  = tx_shift;
      tx_par_n    = tx_par;
      tx_stop2_n  = tx_stop2;
      tx_stopn_n  = tx_stopn;
      tx_pbit_n   = tx_pbit;
      tx_pop      = 1'b0;
      tx_launch   = 1'b0;
      tx_tick     = (tx_cnt == tx_div_m1);
      tx_line_n   = 1'b1;

      case (tx_state)
         TX_IDLE: tx_launch = !tx_empty && cfg_en;
         TX_START: begin
            tx_cnt_n = tx_tick ? '0 : tx_cnt + DIV_W'(1);
            if (tx_tick) tx_state_n = TX_DATA;
         end
         TX_DATA: begin
            tx_cnt_n = tx_tick ? '0 : tx_cnt + DIV_W'(1);
            if (tx_tick) begin
               tx_shift_n = tx_shift >> 1;
               if (tx_bit == tx_last) begin
                  tx_stopn_n = 1'b0;
                  tx_state_n = (tx_par == PAR_NONE) ? TX_STOP : TX_PARITY;
               end else begin
                  tx_bit_n = tx_bit + 3'd1;
               end
            end
         end
         TX_PARITY: begin
            tx_cnt_n = tx_tick ? '0 : tx_cnt + DIV_W'(1);
            if (tx_tick) begin
               tx_stopn_n = 1'b0;
               tx_state_n = TX_STOP;
            end
         end
         TX_STOP: begin
            tx_cnt_n = tx_tick ? '0 : tx_cnt + DIV_W'(1);
            if (tx_tick) begin
               if (tx_stop2 && !tx_stopn) tx_stopn_n = 1'b1;
               else if (!tx_empty && cfg_en) tx_launch = 1'b1;  // no idle gap
               else tx_state_n = TX_IDLE;
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase

      if (tx_launch) begin
         tx_pop      = 1'b1;
         tx_state_n  = TX_START;
         tx_cnt_n    = '0;
         tx_bit_n    = '0;
         tx_stopn_n  = 1'b0;
         tx_div_m1_n = div_eff - DIV_W'(1);
         tx_last_n   = dbits_last(cfg_dbits);
         tx_shift_n  = tx_head & cfg_mask;
         tx_par_n    = cfg_par;
         tx_stop2_n  = cfg_stop2;
         tx_pbit_n   = (^(tx_head & cfg_mask)) ^ (cfg_par == PAR_ODD);
      end

      // Line level is registered from the next state so ser_tx never glitches.
      case (tx_state_n)
         TX_START:  tx_line_n = 1'b0;
         TX_DATA:   tx_line_n = tx_shift_n[0];
         TX_PARITY: tx_line_n = tx_pbit_n;
         default:   tx_line_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tx_state  <= TX_IDLE;
         tx_cnt    <= '0;
         tx_div_m1 <= '0;
         tx_bit    <= '0;
         tx_last   <= '0;
         tx_shift  <= '0;
         tx_par    <= PAR_NONE;
         tx_stop2  <= 1'b0;
         tx_stopn  <= 1'b0;
         tx_pbit   <= 1'b0;
         ser_tx    <= 1'b1;
      end else begin
         tx_state  <= tx_state_n;
         tx_cnt    <= tx_cnt_n;
         tx_div_m1 <= tx_div_m1_n;
         tx_bit    <= tx_bit_n;
         tx_last   <= tx_last_n;
         tx_shift  <= tx_shift_n;
         tx_par    <= tx_par_n;
         tx_stop2  <= tx_stop2_n;
         tx_stopn  <= tx_stopn_n;
         tx_pbit   <= tx_pbit_n;
         ser_tx    <= tx_line_n;
      end
   end

   // ---------------- RX synchroniser + FSM ----------------
   logic             rx_s1, rx_s2;
   rx_state_t        rx_state, rx_state_n;
   logic [DIV_W-1:0] rx_cnt, rx_cnt_n, rx_div_m1, rx_div_m1_n, rx_half_m1, rx_half_m1_n;
   logic [2:0]       rx_bit, rx_bit_n, rx_last, rx_last_n;
   logic [7:0]       rx_word, rx_word_n;
   parity_t          rx_par, rx_par_n;
   logic             rx_acc, rx_acc_n, rx_pe, rx_pe_n, rx_tick;
   logic             rx_push, rx_full, rx_empty, rx_drop;
   logic [9:0]       rx_push_data, rx_head;

   always_comb begin
      rx_state_n   = rx_state;
      rx_cnt_n     = rx_cnt;
      rx_div_m1_n  = rx_div_m1;
      rx_half_m1_n = rx_half_m1;
      rx_bit_n     = rx_bit;
      rx_last_n    = rx_last;
      rx_word_n    = rx_word;
      rx_par_n     = rx_par;
      rx_acc_n     = rx_acc;
      rx_pe_n      = rx_pe;
      rx_push      = 1'b0;
      rx_push_data = {rx_pe, !rx_s2, rx_word};
      rx_tick      = (rx_cnt == rx_div_m1);

      case (rx_state)
         RX_IDLE: begin
            if (!rx_s2 && cfg_en) begin
               rx_state_n   = RX_START;
               rx_cnt_n     = '0;
               rx_div_m1_n  = div_eff - DIV_W'(1);
               rx_half_m1_n = (div_eff >> 1) - DIV_W'(1);
               rx_last_n    = dbits_last(cfg_dbits);
               rx_par_n     = cfg_par;
               rx_bit_n     = '0;
               rx_word_n    = '0;
               rx_acc_n     = 1'b0;
               rx_pe_n      = 1'b0;
            end
         end
         RX_START: begin
            if (rx_cnt == rx_half_m1) begin
               rx_cnt_n   = '0;
               rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;  // high here = glitch
            end else begin
               rx_cnt_n = rx_cnt + DIV_W'(1);
            end
         end
         RX_DATA: begin
            rx_cnt_n = rx_tick ? '0 : rx_cnt + DIV_W'(1);
            if (rx_tick) begin
               rx_word_n[rx_bit] = rx_s2;
               rx_acc_n          = rx_acc ^ rx_s2;
               if (rx_bit == rx_last)
                  rx_state_n = (rx_par == PAR_NONE) ? RX_STOP : RX_PARITY;
               else
                  rx_bit_n = rx_bit + 3'd1;
            end
         end
         RX_PARITY: begin
            rx_cnt_n = rx_tick ? '0 : rx_cnt + DIV_W'(1);
            if (rx_tick) begin
               rx_pe_n    = rx_s2 != (rx_acc ^ (rx_par == PAR_ODD));
               rx_state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            rx_cnt_n = rx_tick ? '0 : rx_cnt + DIV_W'(1);
            if (rx_tick) begin
               rx_push    = 1'b1;
               rx_state_n = rx_s2 ? RX_IDLE : RX_BREAK;
            end
         end
         RX_BREAK: if (rx_s2) rx_state_n = RX_IDLE;
         default:  rx_state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         rx_div_m1  <= '0;
         rx_half_m1 <= '0;
         rx_bit     <= '0;
         rx_last    <= '0;
         rx_word    <= '0;
         rx_par     <= PAR_NONE;
         rx_acc     <= 1'b0;
         rx_pe      <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rx_s1      <= ser_rx;
         rx_s2      <= rx_s1;
         rx_state   <= rx_state_n;
         rx_cnt     <= rx_cnt_n;
         rx_div_m1  <= rx_div_m1_n;
         rx_half_m1 <= rx_half_m1_n;
         rx_bit     <= rx_bit_n;
         rx_last    <= rx_last_n;
         rx_word    <= rx_word_n;
         rx_par     <= rx_par_n;
         rx_acc     <= rx_acc_n;
         rx_pe      <= rx_pe_n;
         if (rx_drop)      rx_overrun <= 1'b1;
         else if (ovr_clr) rx_overrun <= 1'b0;
      end
   end

   // A full FIFO still accepts the frame when the head is popped in the same cycle.
   assign rx_drop = rx_push && rx_full && !rx_ready;

   uart_sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
      .clk(clk), .resetn(resetn),
      .push(rx_push), .wr_data(rx_push_data),
      .pop(rx_ready), .rd_data(rx_head),
      .full(rx_full), .empty(rx_empty), .level(rx_level)
   );

   assign rx_valid = !rx_empty;
   assign rx_data  = rx_head[7:0];
   assign rx_ferr  = rx_head[8];
   assign rx_perr  = rx_head[9];

endmodule
